// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the SRAM-like data port: access sizes,
// bus widths and the layout of one outstanding-response queue entry.
package sram_like_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } q_entry_t;

endpackage

// File: rtl/data_sram_resp_if.sv
// Initiator-side request/response bundle of the SRAM-like data port.
// A request is accepted in any cycle where req and addr_ok are both high;
// data_ok is a one-cycle completion pulse with no back-pressure.
interface data_sram_resp_if;
    import sram_like_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_resp_queue.sv
// Circular buffer of outstanding responses; every valid entry counts down
// towards zero and the head completes once its countdown has expired.
module resp_queue
    import sram_like_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output q_entry_t          o_head
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    q_entry_t        r_q [QDEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    assign o_full = (r_count == CW'(QDEPTH));
    assign o_head = r_q[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_q[i].valid && (r_q[i].cnt != '0)) begin
                    r_q[i].cnt <= r_q[i].cnt - CNT_W'(1);
                end
            end
            // Push never targets the head slot being popped: that needs full.
            if (i_pop) begin
                r_q[r_head].valid <= 1'b0;
                r_head            <= r_head + PW'(1);
            end
            if (i_push) begin
                r_q[r_tail] <= '{valid: 1'b1, wr: i_wr, data: i_data,
                                 cnt: CNT_W'(LATENCY - 1)};
                r_tail      <= r_tail + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Word-organised backing RAM behind an SRAM-like port: loads sample the RAM
// at acceptance and complete in order a fixed LATENCY cycles later.
module data_sram_resp
    import sram_like_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic            clk,
    input  logic            reset,
    data_sram_resp_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic              w_full;
    logic              w_addr_ok;
    logic              w_push;
    logic              w_data_ok;
    logic [IW-1:0]     w_idx;
    logic [DATA_W-1:0] w_rword;
    q_entry_t          w_head;
    logic              w_unused;

    // Size and the non-index address bits are traced by the initiator only.
    assign w_unused  = ^{bus.size, bus.addr[ADDR_W-1:IW+2], bus.addr[1:0]};

    assign w_idx     = bus.addr[IW+1:2];
    assign w_rword   = r_mem[w_idx];
    assign w_addr_ok = ~reset & ~w_full;
    assign w_push    = bus.req & w_addr_ok;
    assign w_data_ok = ~reset & w_head.valid & (w_head.cnt == '0);

    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    assign bus.rdata   = (w_data_ok & ~w_head.wr) ? w_head.data : '0;

    always_ff @(posedge clk) begin
        if (w_push && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    resp_queue #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_wr   (bus.wr),
        .i_data (bus.wr ? '0 : w_rword),
        .i_pop  (w_data_ok),
        .o_full (w_full),
        .o_head (w_head)
    );

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: a LATENCY=2 instance for data-path cases
// and a LATENCY=7 instance for back-pressure and mid-flight reset.
module tb_data_sram_resp;
    import sram_like_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 7;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    logic [31:0] exp_qa[$];
    int          cyc_qa[$];
    logic [31:0] exp_qb[$];
    int          cyc_qb[$];

    data_sram_resp_if bus_a ();
    data_sram_resp_if bus_b ();

    data_sram_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT_A), .QDEPTH(4)) u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    data_sram_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT_B), .QDEPTH(4)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (bus_a.data_ok) begin
            if (exp_qa.size() == 0) begin
                check("a_spurious", bus_a.data_ok, 1'b0);
            end else begin
                check("a_rdata", bus_a.rdata, exp_qa.pop_front());
                check("a_latency", cyc, cyc_qa.pop_front());
            end
        end else begin
            check("a_rdata_idle", bus_a.rdata, 32'h0);
            if (cyc_qa.size() > 0 && cyc_qa[0] < cyc) begin
                check("a_missed", bus_a.data_ok, 1'b1);
                void'(exp_qa.pop_front());
                void'(cyc_qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.data_ok) begin
            if (exp_qb.size() == 0) begin
                check("b_spurious", bus_b.data_ok, 1'b0);
            end else begin
                check("b_rdata", bus_b.rdata, exp_qb.pop_front());
                check("b_latency", cyc, cyc_qb.pop_front());
            end
        end else begin
            check("b_rdata_idle", bus_b.rdata, 32'h0);
            if (cyc_qb.size() > 0 && cyc_qb[0] < cyc) begin
                check("b_missed", bus_b.data_ok, 1'b1);
                void'(exp_qb.pop_front());
                void'(cyc_qb.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue_a(input logic w, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        bus_a.req = 1'b0;
        while (!bus_a.addr_ok && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_addr_ok", bus_a.addr_ok, 1'b1);
        bus_a.req   = 1'b1;
        bus_a.wr    = w;
        bus_a.size  = (s == 4'hF) ? SZ_WORD : SZ_BYTE;
        bus_a.wstrb = s;
        bus_a.addr  = a;
        bus_a.wdata = d;
        exp_qa.push_back(e);
        cyc_qa.push_back(cyc + LAT_A);
        @(negedge clk);
        bus_a.req = 1'b0;
    endtask

    task automatic drive_b(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_b.req   = 1'b1;
        bus_b.wr    = w;
        bus_b.size  = SZ_WORD;
        bus_b.wstrb = 4'hF;
        bus_b.addr  = a;
        bus_b.wdata = d;
    endtask

    task automatic drain_a();
        for (int n = 0; n < 40 && exp_qa.size() > 0; n++) @(negedge clk);
        check("a_drain", exp_qa.size(), 32'd0);
    endtask

    task automatic drain_b();
        for (int n = 0; n < 60 && exp_qb.size() > 0; n++) @(negedge clk);
        check("b_drain", exp_qb.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = SZ_WORD;
        bus_a.wstrb = 4'h0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = SZ_WORD;
        bus_b.wstrb = 4'h0; bus_b.addr = '0; bus_b.wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_addr_ok", bus_a.addr_ok, 1'b0);
        check("rst_data_ok", bus_a.data_ok, 1'b0);
        check("rst_rdata", bus_a.rdata, 32'h0);
        check("rst_b_addr_ok", bus_b.addr_ok, 1'b0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        check("post_rst_addr_ok", bus_a.addr_ok, 1'b1);
        check("post_rst_b_addr_ok", bus_b.addr_ok, 1'b1);

        // Write then read, byte merge, zero strobe, half-word lanes, wrap.
        issue_a(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        issue_a(1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
        issue_a(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0);
        issue_a(1'b1, 4'h4, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0);
        issue_a(1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11AA_3344);
        issue_a(1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0);
        issue_a(1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11AA_3344);
        issue_a(1'b1, 4'hF, 32'h0000_0030, 32'h0000_0000, 32'h0);
        issue_a(1'b1, 4'hC, 32'h0000_0030, 32'h1234_1234, 32'h0);
        issue_a(1'b0, 4'hF, 32'h0000_0031, 32'h0,         32'h1234_0000);
        issue_a(1'b1, 4'hF, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0);
        issue_a(1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A);
        issue_a(1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF);
        issue_a(1'b0, 4'hF, 32'hFFFF_F010, 32'h0,         32'hDEAD_BEEF);
        drain_a();

        // Back-pressure: four accepts fill the queue, the fifth waits for a pop.
        for (int k = 0; k < 9; k++) begin
            case (k)
                0:       drive_b(1'b1, 32'h40, 32'hCAFE_0001);
                1:       drive_b(1'b0, 32'h40, 32'h0);
                2:       drive_b(1'b1, 32'h44, 32'hCAFE_0002);
                3:       drive_b(1'b0, 32'h44, 32'h0);
                default: drive_b(1'b0, 32'h40, 32'h0);
            endcase
            check("b_bp_addr_ok", bus_b.addr_ok, (k < 4) || (k >= 8));
            if (bus_b.addr_ok) begin
                exp_qb.push_back((k == 0 || k == 2) ? 32'h0 :
                                 (k == 3) ? 32'hCAFE_0002 : 32'hCAFE_0001);
                cyc_qb.push_back(cyc + LAT_B);
            end
            @(negedge clk);
        end
        bus_b.req = 1'b0;
        drain_b();

        // Mid-flight reset: three loads in flight, then a one-cycle reset.
        for (int k = 0; k < 3; k++) begin
            drive_b(1'b0, 32'h44, 32'h0);
            @(negedge clk);
        end
        reset_b = 1'b1;
        drive_b(1'b1, 32'h40, 32'h0BAD_0BAD);
        exp_qb.delete();
        cyc_qb.delete();
        #1;
        check("b_rst_data_ok", bus_b.data_ok, 1'b0);
        check("b_rst_addr_ok", bus_b.addr_ok, 1'b0);
        check("b_rst_rdata", bus_b.rdata, 32'h0);
        @(negedge clk);
        reset_b = 1'b0;
        drive_b(1'b0, 32'h40, 32'h0);
        #1;
        check("b_post_rst_addr_ok", bus_b.addr_ok, 1'b1);
        exp_qb.push_back(32'hCAFE_0001);
        cyc_qb.push_back(cyc + LAT_B);
        @(negedge clk);
        bus_b.req = 1'b0;
        drain_b();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
